voice_sequencer: RTL and testbench
==================================

Name: voice_sequencer

Overview:
- Step sequencer that drives one pulse-wave voice oscillator.
- Holds an 8-entry table of frequency/pulse-width pairs, written through a simple register port.
- On start, plays table entries in order for a programmed note time, with an optional gap between notes. Supports one-shot or looped playback.
- Emits the oscillator's enable strobe, frequency, pulse width and a gate used by the downstream mixer for muting.

Parameters:
- STEPS, 8: table depth; must be a power of two.
- STEP_W, 3: step index width, log2(STEPS).
- SAMPLE_DIV, 4: clocks per oscillator enable strobe; must be ≥1.
- LEN_W, 16: width of the note/gap length counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; the block has one clock, and reset is asynchronous and active-low.
- wr_en  in  1  table write strobe.
- wr_addr  in  STEP_W  table entry written.
- wr_freq  in  16  frequency word for that entry; 0 = rest.
- wr_pw  in  12  pulse width for that entry.
- start  in  1  begin playback at step 0.
- stop  in  1  abort playback.
- loop  in  1  1 = wrap to step 0 after last_step.
- last_step  in  STEP_W  final step index played.
- note_len  in  LEN_W  NOTE duration in clocks; 0 is treated as 1.
- gap_len  in  LEN_W  GAP duration in clocks; 0 = no gap.
- voice_en  out  1  oscillator enable strobe.
- frequency  out  16  current step's frequency word.
- pulsewidth  out  12  current step's pulse width.
- gate  out  1  1 = current note audible.
- step  out  STEP_W  current step index.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at natural end of a one-shot sequence.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; table entries all 0; prescaler 0.
  - All outputs 0.
- Table write: on wr_en, the entry at wr_addr takes wr_freq/wr_pw on the same edge. Writes are allowed in any state.
- Latching rule: frequency/pulsewidth are latched only on NOTE entry. A write to the playing step takes effect the next time that step is entered.
- Config shadow: loop, last_step, note_len and gap_len are captured on accepted start and held until IDLE. Input changes during playback are ignored.
- Prescaler: free-runs 0..SAMPLE_DIV-1 whenever out of reset. voice_en = 1 for one cycle when the count is SAMPLE_DIV-1 and state != IDLE. voice_en is always 0 in IDLE.
- States:
  - IDLE:
    - start && !stop → NOTE on the next edge, with step=0, entry 0 loaded, timer=max(note_len,1).
  - NOTE:
    - gate = (frequency != 0).
    - Timer decrements each clock; the state lasts exactly max(note_len,1) clocks.
    - At expiry: if gap_len != 0 → GAP, timer=gap_len. Else → advance.
  - GAP:
    - gate = 0; frequency/pulsewidth hold.
    - Lasts exactly gap_len clocks, then → advance.
  - advance:
    - step != last_step → NOTE with step+1.
    - Else if loop → NOTE with step=0.
    - Else → IDLE, done=1 for one cycle. step, frequency and pulsewidth hold their last values; gate=0.
- Stop:
  - stop in any non-IDLE state → IDLE on the next edge; gate=0; no done pulse.
  - stop has priority over start and over expiry in the same cycle.
- start while busy: ignored.
- Step wrap: step increments modulo STEPS. last_step = STEPS-1 is legal.
- busy is registered; it is 1 from the cycle after start through the final NOTE/GAP cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Write entries 0..2 = (freq 0x1000, pw 0x800), (0x2000, 0x400), (0x3000, 0xC00); last_step=2, note_len=5, gap_len=2, loop=0; pulse start → frequency 0x1000/0x2000/0x3000, each with gate high for exactly 5 clocks and low for 2; then busy falls, done pulses once, gate=0.
2. SAMPLE_DIV=4, any playback → voice_en pulses exactly every 4 clocks while busy; voice_en never asserts in IDLE, including after reset.
3. loop=1, last_step=1, note_len=3, gap_len=0 → step sequence 0,1,0,1…; gate stays high continuously; done never pulses. Assert stop → IDLE next cycle, gate=0, no done.
4. Entry 1 freq=0 (rest), last_step=2 → step 1 holds gate=0 for its full note_len while frequency=0; steps 0 and 2 are audible.
5. During step 0, write entry 0 = 0x7777, and change note_len from 5 to 9 → current note and length are unchanged; on restart after completion, frequency 0x7777 appears, and the new note_len applies only if it was present at that start.
6. Assert rst_n low mid-NOTE for 1 clock → all outputs 0 immediately (asynchronously); table cleared; start after release plays frequency 0 with gate=0.

Source files
------------

// File: rtl/voice_sequencer.sv
// rtl/voice_sequencer.sv - step sequencer driving one pulse-wave voice oscillator
//
// Plays an 8-entry frequency/pulse-width table in order, holding each entry
// for a note time plus an optional gap, one-shot or looped.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en/wr_addr          table write strobe and entry index
//   wr_freq/wr_pw          frequency word (0 = rest) and pulse width to store
//   start/stop             begin playback at step 0 / abort playback
//   loop, last_step        wrap after last_step / final step played
//   note_len, gap_len      note time (0 acts as 1) / gap time (0 = none)
//   voice_en               oscillator enable strobe, every SAMPLE_DIV clocks
//   frequency/pulsewidth   values latched for the current step
//   gate                   current note audible
//   step                   current step index
//   busy                   sequencer not idle
//   done                   one-cycle pulse at the end of a one-shot run
module voice_sequencer #(
  parameter int STEPS      = 8,
  parameter int STEP_W     = 3,
  parameter int SAMPLE_DIV = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [15:0]       wr_freq,
  input  logic [11:0]       wr_pw,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [STEP_W-1:0] last_step,
  input  logic [LEN_W-1:0]  note_len,
  input  logic [LEN_W-1:0]  gap_len,
  output logic              voice_en,
  output logic [15:0]       frequency,
  output logic [11:0]       pulsewidth,
  output logic              gate,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NOTE = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SAMPLE_DIV - 1);

  logic [15:0]       r_tbl_freq [STEPS];
  logic [11:0]       r_tbl_pw   [STEPS];

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_timer;
  logic [STEP_W-1:0] r_step;
  logic [15:0]       r_freq;
  logic [11:0]       r_pw;
  logic              r_gate;
  logic              r_busy;
  logic              r_done;
  logic              r_voice_en;
  logic [PRE_W-1:0]  r_presc;

  // configuration captured at start, frozen for the whole run
  logic              r_loop;
  logic [STEP_W-1:0] r_last;
  logic [LEN_W-1:0]  r_note;
  logic [LEN_W-1:0]  r_gap;

  logic [1:0]        w_state_nxt;
  logic [LEN_W-1:0]  w_timer_nxt;
  logic [STEP_W-1:0] w_step_nxt;
  logic              w_load;
  logic              w_done_nxt;
  logic              w_capture;
  logic [15:0]       w_freq_nxt;
  logic [11:0]       w_pw_nxt;
  logic [PRE_W-1:0]  w_presc_nxt;
  logic [LEN_W-1:0]  w_note_eff;

  assign w_note_eff  = (note_len == '0) ? LEN_W'(1) : note_len;
  assign w_presc_nxt = (r_presc == PRE_MAX) ? '0 : r_presc + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_step_nxt  = r_step;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_state_nxt = NOTE;
          w_step_nxt  = '0;
          w_timer_nxt = w_note_eff;
          w_load      = 1'b1;
          w_capture   = 1'b1;
        end
      end
      NOTE, GAP: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (r_timer != LEN_W'(1)) begin
          w_timer_nxt = r_timer - 1'b1;
        end else if (r_state == NOTE && r_gap != '0) begin
          w_state_nxt = GAP;
          w_timer_nxt = r_gap;
        end else if (r_step != r_last) begin
          w_state_nxt = NOTE;
          w_step_nxt  = r_step + 1'b1;
          w_timer_nxt = r_note;
          w_load      = 1'b1;
        end else if (r_loop) begin
          w_state_nxt = NOTE;
          w_step_nxt  = '0;
          w_timer_nxt = r_note;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A write landing on the same edge as a step entry is seen on the next entry.
  assign w_freq_nxt = w_load ? r_tbl_freq[w_step_nxt] : r_freq;
  assign w_pw_nxt   = w_load ? r_tbl_pw[w_step_nxt]   : r_pw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        r_tbl_freq[i] <= '0;
        r_tbl_pw[i]   <= '0;
      end
    end else if (wr_en) begin
      r_tbl_freq[wr_addr] <= wr_freq;
      r_tbl_pw[wr_addr]   <= wr_pw;
    end
  end

  // Status outputs are registered from next-state values so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_step     <= '0;
      r_freq     <= '0;
      r_pw       <= '0;
      r_gate     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_voice_en <= 1'b0;
      r_presc    <= '0;
      r_loop     <= 1'b0;
      r_last     <= '0;
      r_note     <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_step     <= w_step_nxt;
      r_freq     <= w_freq_nxt;
      r_pw       <= w_pw_nxt;
      r_gate     <= (w_state_nxt == NOTE) && (w_freq_nxt != '0);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
      r_presc    <= w_presc_nxt;
      r_voice_en <= (w_presc_nxt == PRE_MAX) && (w_state_nxt != IDLE);
      if (w_capture) begin
        r_loop <= loop;
        r_last <= last_step;
        r_note <= w_note_eff;
        r_gap  <= gap_len;
      end
    end
  end

  assign voice_en   = r_voice_en;
  assign frequency  = r_freq;
  assign pulsewidth = r_pw;
  assign gate       = r_gate;
  assign step       = r_step;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_voice_sequencer.sv
// tb/tb_voice_sequencer.sv - self-checking bench for voice_sequencer
module tb_voice_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_freq;
  logic [11:0] wr_pw;
  logic        start;
  logic        stop;
  logic        loop;
  logic [2:0]  last_step;
  logic [15:0] note_len;
  logic [15:0] gap_len;
  logic        voice_en;
  logic [15:0] frequency;
  logic [11:0] pulsewidth;
  logic        gate;
  logic [2:0]  step;
  logic        busy;
  logic        done;

  voice_sequencer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_pw(wr_pw), .start(start), .stop(stop),
    .loop(loop), .last_step(last_step), .note_len(note_len), .gap_len(gap_len),
    .voice_en(voice_en), .frequency(frequency), .pulsewidth(pulsewidth),
    .gate(gate), .step(step), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  step;
    logic [15:0] freq;
    logic [11:0] pw;
    logic        gate;
    int          cycles;
  } seg_t;

  seg_t        q[$];
  logic [15:0] m_freq [8];
  logic [11:0] m_pw   [8];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_ven = 0;
  bit          ven_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] f, input logic [11:0] p);
    wr_en = 1'b1; wr_addr = 3'(a); wr_freq = f; wr_pw = p;
    @(negedge clk);
    wr_en = 1'b0;
    m_freq[a] = f;
    m_pw[a]   = p;
  endtask

  task automatic push_note(input int s, input int nl, input int gl);
    seg_t sg;
    sg.step = 3'(s); sg.freq = m_freq[s]; sg.pw = m_pw[s];
    sg.gate = (m_freq[s] != 16'h0);
    sg.cycles = (nl == 0) ? 1 : nl;
    q.push_back(sg);
    if (gl > 0) begin
      sg.gate = 1'b0;
      sg.cycles = gl;
      q.push_back(sg);
    end
  endtask

  task automatic push_oneshot(input int last, input int nl, input int gl);
    for (int s = 0; s <= last; s++) push_note(s, nl, gl);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_segs();
    seg_t sg;
    while (q.size() > 0) begin
      sg = q.pop_front();
      for (int i = 0; i < sg.cycles; i++) begin
        chk("step",  32'(step),       32'(sg.step));
        chk("freq",  32'(frequency),  32'(sg.freq));
        chk("pw",    32'(pulsewidth), 32'(sg.pw));
        chk("gate",  32'(gate),       32'(sg.gate));
        chk("busy",  32'(busy),       32'd1);
        chk("done0", 32'(done),       32'd0);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_done(input int last, input logic [15:0] f, input logic [11:0] p);
    chk("done",      32'(done),       32'd1);
    chk("busy_end",  32'(busy),       32'd0);
    chk("gate_end",  32'(gate),       32'd0);
    chk("step_hold", 32'(step),       32'(last));
    chk("freq_hold", 32'(frequency),  32'(f));
    chk("pw_hold",   32'(pulsewidth), 32'(p));
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_freq"}, 32'(frequency),  32'd0);
    chk({tag, "_pw"},   32'(pulsewidth), 32'd0);
    chk({tag, "_gate"}, 32'(gate),       32'd0);
    chk({tag, "_step"}, 32'(step),       32'd0);
    chk({tag, "_busy"}, 32'(busy),       32'd0);
    chk({tag, "_done"}, 32'(done),       32'd0);
    chk({tag, "_ven"},  32'(voice_en),   32'd0);
  endtask

  // voice_en must be confined to busy cycles and strobe every 4 clocks
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("ven_idle", 32'(voice_en & ~busy), 32'd0);
      if (voice_en) begin
        if (ven_seen) chk("ven_period", 32'(cyc - last_ven), 32'd4);
        ven_seen = 1'b1;
        last_ven = cyc;
      end
      if (!busy) ven_seen = 1'b0;
    end else begin
      ven_seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_pw = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_step = '0;
    note_len = '0; gap_len = '0;
    for (int i = 0; i < 8; i++) begin m_freq[i] = '0; m_pw[i] = '0; end
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_all_zero("post_rst");

    // one-shot with gaps
    wr(0, 16'h1000, 12'h800);
    wr(1, 16'h2000, 12'h400);
    wr(2, 16'h3000, 12'hC00);
    loop = 1'b0; last_step = 3'd2; note_len = 16'd5; gap_len = 16'd2;
    push_oneshot(2, 5, 2);
    pulse_start();
    run_segs();
    check_done(2, 16'h3000, 12'hC00);

    // looped playback, aborted by stop
    loop = 1'b1; last_step = 3'd1; note_len = 16'd3; gap_len = 16'd0;
    for (int k = 0; k < 4; k++) push_note(k % 2, 3, 0);
    pulse_start();
    run_segs();
    chk("loop_wrap_step", 32'(step), 32'd0);
    chk("loop_wrap_gate", 32'(gate), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_gate", 32'(gate), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("stop_done2", 32'(done), 32'd0);
    loop = 1'b0;

    // rest step in the middle
    wr(1, 16'h0000, 12'h123);
    last_step = 3'd2; note_len = 16'd4; gap_len = 16'd1;
    push_oneshot(2, 4, 1);
    pulse_start();
    run_segs();
    check_done(2, 16'h3000, 12'hC00);

    // writes and config changes during a note are not seen until restart
    last_step = 3'd0; note_len = 16'd5; gap_len = 16'd0;
    push_oneshot(0, 5, 0);
    pulse_start();
    fork
      run_segs();
      begin
        wr(0, 16'h7777, 12'h111);
        note_len = 16'd9;
        pulse_start();
      end
    join
    check_done(0, 16'h1000, 12'h800);
    push_oneshot(0, 9, 0);
    pulse_start();
    run_segs();
    check_done(0, 16'h7777, 12'h111);

    // asynchronous reset mid-note clears outputs and table
    note_len = 16'd20;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin m_freq[i] = '0; m_pw[i] = '0; end
    note_len = 16'd3;
    push_oneshot(0, 3, 0);
    pulse_start();
    run_segs();
    check_done(0, 16'h0000, 12'h000);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
